// File: rtl/nibble_tx_pkg.sv
// Shared types and constants for the nibble link transmitter.
// State enum, nibble width and the default handshake wait limit.
package nibble_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE
  } state_e;

  localparam int NIBBLE_W = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/nibble_tx_timer.sv
// Per-phase wait counter; clr restarts it, en counts waiting cycles.
// Ports: clk, reset (sync, low), clr, en -> expired on the last cycle.
module nibble_tx_timer
  import nibble_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts cycles already spent, so LAST marks the final one.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/nibble_transmitter.sv
// 4-phase valid/ack nibble transmitter, MSB nibble first.
// Ports: tx_* local side, data_out/valid/ack link; NIBBLE_TX_TIMEOUT_EN.
module nibble_transmitter
  import nibble_tx_pkg::*;
#(
  parameter int NIBBLES        = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NIBBLE_W*NIBBLES-1:0]  tx_data,
  input  logic                         tx_start,
  output logic                         tx_busy,
  output logic                         tx_done,
  output logic                         tx_err,
  output logic [NIBBLE_W-1:0]          data_out,
  output logic                         valid,
  input  logic                         ack
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT =
    CW'(NIBBLES - 1);

  state_e              state_q, state_d;
  logic [W-1:0]        sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NIBBLE_W-1:0] dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tmo;

`ifdef NIBBLE_TX_TIMEOUT_EN
  logic tmr_clr;
  logic tmr_en;

  assign tmr_en  = (state_q != IDLE);
  assign tmr_clr = (state_d != state_q) &&
                   (state_d != IDLE);

  nibble_tx_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmo)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (tx_start && !ack) begin
          state_d = DRIVE;
          dout_d  = tx_data[W-1 -: NIBBLE_W];
          sr_d    = tx_data << NIBBLE_W;
          cnt_d   = LAST_CNT;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (ack) begin
          state_d = RELEASE;
          valid_d = 1'b0;
        end else if (tmo) begin
          state_d = IDLE;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      RELEASE: begin
        if (!ack) begin
          if (cnt_q != '0) begin
            state_d = DRIVE;
            cnt_d   = cnt_q - 1'b1;
            dout_d  = sr_q[W-1 -: NIBBLE_W];
            sr_d    = sr_q << NIBBLE_W;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_out = dout_q;
  assign valid    = valid_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;

endmodule

// File: tb/tb_nibble_transmitter.sv
// Self-checking bench for nibble_transmitter with ack <= valid receiver.
// Table vectors, corner sequences and random words vs a nibble model.
module tb_nibble_transmitter;

`ifdef NIBBLE_TX_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_start = 1'b0;
  logic        tx_busy, tx_done, tx_err;
  logic [3:0]  data_out;
  logic        valid;
  logic        ack = 1'b0;
  logic        hold_ack = 1'b0;
  logic        ack_lvl = 1'b0;

  nibble_transmitter #(
    .NIBBLES(4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_err  (tx_err),
    .data_out(data_out),
    .valid   (valid),
    .ack     (ack)
  );

  always #5 clk = ~clk;

  // Model receiver: registers valid as ack unless forced.
  always @(posedge clk)
    ack <= hold_ack ? ack_lvl : valid;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, a, e);
    end
  endtask

  // Monitor: nibbles at each valid rise, pulse lengths.
  logic [3:0] cap_q[$];
  int         len_q[$];
  int         done_n = 0;
  logic       vprev = 1'b0;
  logic [3:0] dprev = '0;
  int         len = 0;

  always @(negedge clk) begin
    if (tx_done) done_n++;
    if (valid && !vprev) begin
      cap_q.push_back(data_out);
      len = 1;
    end else if (valid) begin
      len++;
      chk("dout_stable", 32'(data_out), 32'(dprev));
    end else if (vprev) begin
      len_q.push_back(len);
    end
    vprev = valid;
    dprev = data_out;
  end

  task automatic clr_mon();
    cap_q.delete();
    len_q.delete();
  endtask

  task automatic send(input logic [15:0] w,
                      output int lat);
    int k;
    logic [3:0] top;
    top = w[15:12];
    tx_data  = w;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 16'($urandom);
    chk("first_valid", 32'(valid), 32'd1);
    chk("first_nib", 32'(data_out), 32'(top));
    k = 0;
    while (!tx_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!tx_done) chk("done_wait", 32'd0, 32'd1);
    lat = k;
    chk("busy_at_done", 32'(tx_busy), 32'd0);
  endtask

  task automatic chk_seq(input string nm,
                         input logic [15:0] e);
    logic [3:0] en;
    chk({nm, "_count"}, 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        en = 4'((e >> (12 - 4 * i)) & 16'hF);
        chk({nm, "_nib"}, 32'(cap_q[i]), 32'(en));
      end
    end
  endtask

  task automatic chk_lens();
    chk("pulse_count", 32'(len_q.size()), 32'd4);
    foreach (len_q[i])
      chk("pulse_len", 32'(len_q[i]), 32'd2);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [3:0]  n0, n1, n2, n3;
    int          lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;
    int k;
    logic ok;
    logic [15:0] w;
    logic [15:0] mexp;

    vecs[0] = '{16'hA5C3, 4'hA, 4'h5, 4'hC, 4'h3, 16};
    vecs[1] = '{16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 16};
    vecs[2] = '{16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF, 16};
    vecs[3] = '{16'h1E2D, 4'h1, 4'hE, 4'h2, 4'hD, 16};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      clr_mon();
      send(vecs[i].w, lat);
      chk("vec_latency", 32'(lat), 32'(vecs[i].lat));
      chk_seq("vec", {vecs[i].n0, vecs[i].n1,
                      vecs[i].n2, vecs[i].n3});
      chk_lens();
      repeat (3) @(negedge clk);
    end

    // back-to-back: start in the tx_done cycle
    clr_mon();
    send(16'h0001, lat);
    chk_seq("b2b_first", 16'h0001);
    clr_mon();
    send(16'hBEEF, lat);
    chk("b2b_latency", 32'(lat), 32'd16);
    chk_seq("b2b_second", 16'hBEEF);
    repeat (3) @(negedge clk);

    // start during an active word is ignored
    clr_mon();
    done_n = 0;
    tx_data  = 16'hFFFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    tx_data  = 16'h1234;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (40) @(negedge clk);
    chk_seq("ignore", 16'hFFFF);
    chk("ignore_done", 32'(done_n), 32'd1);
    chk("ignore_busy", 32'(tx_busy), 32'd0);

    // start while ack high is ignored
    hold_ack = 1'b1;
    ack_lvl  = 1'b1;
    repeat (2) @(negedge clk);
    clr_mon();
    tx_data  = 16'h5A5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      if (valid || tx_busy) ok = 1'b0;
      @(negedge clk);
    end
    chk("ackhi_idle", 32'(ok), 32'd1);
    chk("ackhi_nibs", 32'(cap_q.size()), 32'd0);
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);

    // reset during the third nibble
    clr_mon();
    tx_data  = 16'h9876;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    k = 0;
    while (cap_q.size() < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_reach", 32'(cap_q.size()), 32'd3);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", 32'(valid), 32'd0);
    chk("rstmid_dout", 32'(data_out), 32'd0);
    chk("rstmid_busy", 32'(tx_busy), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clr_mon();
    send(16'h9876, lat);
    chk_seq("rstmid_again", 16'h9876);

`ifdef NIBBLE_TX_TIMEOUT_EN
    // timeout with ack stuck low
    repeat (3) @(negedge clk);
    hold_ack = 1'b1;
    ack_lvl  = 1'b0;
    repeat (2) @(negedge clk);
    done_n = 0;
    tx_data  = 16'hC0DE;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    k = 0;
    while (valid && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("tmo_cycles", 32'(k), 32'd8);
    chk("tmo_err", 32'(tx_err), 32'd1);
    chk("tmo_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("tmo_nodone", 32'(done_n), 32'd0);
    chk("tmo_sticky", 32'(tx_err), 32'd1);
    hold_ack = 1'b0;
    repeat (2) @(negedge clk);
    clr_mon();
    send(16'h4321, lat);
    chk("tmo_errclr", 32'(tx_err), 32'd0);
    chk_seq("tmo_after", 16'h4321);
`endif

    // random words vs nibble-order model
    repeat (20) begin
      w = 16'($urandom);
      mexp = '0;
      for (int i = 0; i < 4; i++)
        mexp = (mexp << 4) |
               ((w >> (12 - 4 * i)) & 16'hF);
      clr_mon();
      send(w, lat);
      chk("rnd_latency", 32'(lat), 32'd16);
      chk_seq("rnd", mexp);
      chk_lens();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/nibble_transmitter.md
# nibble_transmitter

Transmitting end of the 4-bit valid/ack nibble link consumed by the FPGA receiver block. Accepts a 16-bit word from local logic, splits it into four nibbles and sends them MSB nibble first over `data_out`/`valid`, completing a 4-phase handshake against the receiver's `ack` for every nibble. It drives the receiver inputs directly, and both ends share `clk`.

## Interface
- `NIBBLES`, 4: nibbles per word; word width is 4*NIBBLES.
- `TIMEOUT_CYCLES`, 1024: maximum wait cycles per handshake phase; used only when `NIBBLE_TX_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `tx_data`  in  4*NIBBLES  word to send; sampled only on an accepted start.
- `tx_start`  in  1  start request.
- `tx_busy`  out  1  high from accepted start until return to IDLE.
- `tx_done`  out  1  one-cycle pulse when the word has completed.
- `tx_err`  out  1  sticky timeout flag.
- `data_out`  out  4  current nibble, stable while `valid` is high.
- `valid`  out  1  nibble valid toward the receiver.
- `ack`  in  1  receiver acknowledge, synchronous to `clk`.

## Operation
- Reset (`reset`=0 at an edge): state IDLE. `data_out`=0, `valid`=0, `tx_busy`=0, `tx_done`=0, `tx_err`=0, shift register and counters cleared. Reset overrides everything, including mid-word.
- States:
  - IDLE: start is accepted when `tx_start`=1 and `ack`=0. On accept, latch `tx_data`, clear `tx_err` and go to DRIVE. A `tx_start` seen while `ack`=1 is ignored.
  - DRIVE: `valid`=1 and `data_out` holds the current nibble. Stay until `ack`=1 is sampled, then go to RELEASE.
  - RELEASE: `valid`=0 and `data_out` holds its value. Stay until `ack`=0 is sampled. If nibbles remain, load the next nibble and go to DRIVE. Otherwise go to IDLE and pulse `tx_done`.
- Nibble order: `tx_data[4N-1:4N-4]` goes first and `tx_data[3:0]` goes last.
- `tx_start` is ignored in any state other than IDLE, and `tx_data` changes during a word have no effect.
- A start is accepted in the same cycle as `tx_done`, so back-to-back words need no idle gap.
- The nibble counter is `$clog2(NIBBLES)` bits wide, counts down and does not wrap.

## Timing
- Edge E1 samples the accepted start. `valid` is high after E1 with the first nibble on `data_out`.
- A receiver that registers `ack <= valid` gives 4 cycles per nibble: `valid` high for 2 cycles, then low for 2 cycles.
- With that receiver, `tx_done` is high for the cycle after E(4*NIBBLES+1), which is 16 cycles after `valid` first rises for the default parameters.
- `data_out` changes only on the edge that enters DRIVE. It never changes while `valid`=1.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `NIBBLE_TX_TIMEOUT_EN` defined:
  - A per-phase wait counter clears on every DRIVE/RELEASE entry.
  - If the counter reaches `TIMEOUT_CYCLES` without the awaited `ack` level, the next edge sets `valid`=0, sets `tx_err`=1, returns to IDLE with `tx_busy`=0, and does not pulse `tx_done`.
  - `tx_err` stays high until the next accepted start or until reset.
- Macro undefined: there is no counter and the FSM waits indefinitely. `tx_err` is tied to 0.

## Structure
- Package `nibble_tx_pkg`:
  - state enum `{IDLE, DRIVE, RELEASE}`;
  - `NIBBLE_W = 4`;
  - default `TIMEOUT_CYCLES`.
- Sub-module `nibble_tx_timer`: a loadable wait counter with a clear input and a `expired` output. It is instantiated only under `NIBBLE_TX_TIMEOUT_EN`.

## Test plan
- Send `tx_data`=0xA5C3 to a model receiver with `ack <= valid` → `data_out` during `valid` is A, 5, C, 3. Each `valid` pulse lasts 2 cycles. `tx_done` pulses 16 cycles after the first `valid` rise, and `tx_busy` is 0 afterwards.
- Pulse `tx_start` with 0x1234 during an active word 0xFFFF → only F, F, F, F are transmitted and no second word follows.
- Assert `tx_start` with 0xBEEF in the `tx_done` cycle of word 0x0001 → `valid` rises next cycle with nibble B.
- Hold `ack`=1 in IDLE and pulse `tx_start` → no transfer. `valid` and `tx_busy` stay at 0.
- Drive `reset`=0 during the third nibble of 0x9876 → after the next edge `valid`=0, `data_out`=0 and `tx_busy`=0. After release, a new start sends all four nibbles.
- With `NIBBLE_TX_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, hold `ack`=0 after start → `valid` falls and `tx_err`=1 after 8 DRIVE cycles, with no `tx_done`. The next accepted start clears `tx_err`.
